ctrl_conv_output_par: RTL and testbench
=======================================

Name: ctrl_conv_output_par

Overview:
Next-generation convolution output controller for the parallel datapath. It sequences N_LANES MAC lanes over the X memory with a configurable stride, and produces per-beat window base addresses, a lane-valid mask and load strobes. It waits for the MAC result, then presents it on an AXI-style valid/ready output. It sits between the X/F memory loaders (conv_start) and the MAC array/output interface, replacing the single-lane, stride-1 controller.

Parameters:
F_MEM_SIZE, 4, filter taps
X_MEM_SIZE, 8, input vector length
STRIDE, 1, window step between consecutive outputs
N_LANES, 2, parallel MAC lanes per output beat
X_MEM_ADDR_WIDTH, 3, X memory address width
F_MEM_ADDR_WIDTH, 2, F memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
conv_start  in  1  level; rising edge starts a convolution; low mid-run requests abort
mac_valid  in  1  one-cycle pulse from MAC array: current beat's results ready
m_ready_y  in  1  downstream ready
load_xaddr_en  out  1  one-cycle strobe: lanes load windows at load_xaddr_val + i*STRIDE
load_xaddr_val  out  X_MEM_ADDR_WIDTH  lane-0 window base address
lane_mask  out  N_LANES  bit i set = lane i holds a real output this beat
m_valid_y  out  1  output beat valid
conv_done  out  1  one-cycle pulse after last beat accepted
busy  out  1  high in any state except IDLE

Behaviour:
- Clock/reset: single clock clk; reset synchronous active-high. Reset forces IDLE, load_xaddr_val=0, lane_mask=0, all strobes/valid/done/busy=0, start edge register=0.
- Derived constants: N_OUT=(X_MEM_SIZE-F_MEM_SIZE)/STRIDE+1; N_BEATS=ceil(N_OUT/N_LANES); BEAT_STEP=N_LANES*STRIDE.
- Elaboration checks (fatal): X_MEM_SIZE>=F_MEM_SIZE; (X_MEM_SIZE-F_MEM_SIZE)%STRIDE==0; STRIDE>=1; N_LANES>=1.
- Start edge: start_pulse = conv_start & ~conv_start_q.
- FSM states: IDLE, LOAD, COMPUTE, OUT, DONE.
  - IDLE: on start_pulse go to LOAD with base=0 and beat counter=0.
  - LOAD: one cycle with load_xaddr_en=1; lane_mask valid from this cycle until the beat is accepted. Next state is COMPUTE.
  - COMPUTE: wait for mac_valid, then go to OUT.
  - OUT: m_valid_y=1, held until m_ready_y. On the handshake:
    - last beat: go to DONE;
    - otherwise: base += BEAT_STEP, beat+1, go to LOAD.
  - DONE: conv_done=1 for one cycle, base reset to 0, then IDLE.
- Latency: start edge to load strobe is 1 cycle. mac_valid to m_valid_y is 1 cycle. Last handshake to conv_done is 1 cycle.
- lane_mask: all ones except on the last beat, where the low (N_OUT - (N_BEATS-1)*N_LANES) bits are set.
- Valid/ready: m_valid_y never drops without a handshake. m_valid_y and lane_mask are stable while stalled.
- Abort: conv_start low in LOAD or COMPUTE returns to IDLE next cycle with no conv_done. In OUT, the abort is deferred until the pending handshake completes, then the FSM goes to IDLE with no conv_done.
- mac_valid outside COMPUTE is ignored.
- start_pulse outside IDLE is ignored.
- Back-to-back runs: conv_start must fall and rise again; a level held high never restarts.
- Reset asserted in any state wins over every other event.

Optional Feature:
CTRL_STALL_CNT_EN: when defined, adds output port stall_cnt[15:0].
- Counts cycles with m_valid_y & ~m_ready_y, saturating at 0xFFFF.
- Cleared by reset and by start_pulse.
When undefined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Package conv_ctrl_pkg holds:
  - state enum conv_out_state_e;
  - functions n_out() and n_beats();
  - width helper for the beat counter (clog2(N_BEATS+1)).
- One natural sub-module: conv_start_edge (rising-edge detector, registered), reusable by the input loaders.

Test Plan:
- Defaults (N_OUT=5, N_BEATS=3), m_ready_y tied 1, mac_valid 2 cycles after each strobe -> bases 0,2,4; masks 11,11,01; exactly 3 handshakes; conv_done one cycle after the 3rd.
- STRIDE=2, X_MEM_SIZE=12, F_MEM_SIZE=4, N_LANES=2 (N_OUT=5, BEAT_STEP=4) -> bases 0,4,8; masks 11,11,01.
- Stall m_ready_y low 5 cycles on beat 1 -> m_valid_y, base and mask stable for 5 cycles; stall_cnt=5 with CTRL_STALL_CNT_EN.
- Drop conv_start in COMPUTE of beat 2 -> IDLE next cycle, no conv_done. Drop it in OUT -> the handshake still completes, then IDLE, no conv_done.
- Hold conv_start high after conv_done, then toggle low/high -> no restart until the new edge; second run repeats bases from 0.
- Assert reset during OUT -> next cycle all outputs 0 and state IDLE; a spurious mac_valid in IDLE causes no output.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution output controller
// and the loaders that sit in front of it.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_OUT,
    S_DONE
  } conv_out_state_e;

  function automatic int n_out(input int x, input int f, input int s);
    return (x - f) / ((s < 1) ? 1 : s) + 1;
  endfunction

  function automatic int n_beats(input int no, input int nl);
    return (no + nl - 1) / ((nl < 1) ? 1 : nl);
  endfunction

  function automatic int beat_cnt_w(input int nb);
    return (nb < 1) ? 1 : $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/ctrl_conv_output_par_if.sv
// Control bundle between loaders, MAC array, output sink and the
// parallel convolution output controller.
interface ctrl_conv_output_par_if #(
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int N_LANES          = 2
) ();

  logic                        conv_start;
  logic                        mac_valid;
  logic                        m_ready_y;
  logic                        load_xaddr_en;
  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val;
  logic [N_LANES-1:0]          lane_mask;
  logic                        m_valid_y;
  logic                        conv_done;
  logic                        busy;

  modport master (
    input  conv_start,
    input  mac_valid,
    input  m_ready_y,
    output load_xaddr_en,
    output load_xaddr_val,
    output lane_mask,
    output m_valid_y,
    output conv_done,
    output busy
  );

  modport slave (
    output conv_start,
    output mac_valid,
    output m_ready_y,
    input  load_xaddr_en,
    input  load_xaddr_val,
    input  lane_mask,
    input  m_valid_y,
    input  conv_done,
    input  busy
  );

endinterface

// File: rtl/conv_start_edge.sv
// Registered rising-edge detector for a level start request.
module conv_start_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/ctrl_conv_output_par.sv
// Parallel convolution output controller: N_LANES windows per beat.
// Optional CTRL_STALL_CNT_EN adds a saturating output-stall counter.
module ctrl_conv_output_par
  import conv_ctrl_pkg::*;
#(
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_SIZE       = 8,
  parameter int STRIDE           = 1,
  parameter int N_LANES          = 2,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  ctrl_conv_output_par_if.master       bus
`ifdef CTRL_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int N_OUT      = n_out(X_MEM_SIZE, F_MEM_SIZE, STRIDE);
  localparam int N_BEATS    = n_beats(N_OUT, N_LANES);
  localparam int BEAT_STEP  = N_LANES * STRIDE;
  localparam int BW         = beat_cnt_w(N_BEATS);
  localparam int LAST_LANES = N_OUT - (N_BEATS - 1) * N_LANES;

  if (X_MEM_SIZE < F_MEM_SIZE) begin : g_chk_size
    $fatal(1, "X_MEM_SIZE must be >= F_MEM_SIZE");
  end
  if (STRIDE < 1) begin : g_chk_stride
    $fatal(1, "STRIDE must be >= 1");
  end
  if (N_LANES < 1) begin : g_chk_lanes
    $fatal(1, "N_LANES must be >= 1");
  end
  if (STRIDE >= 1 && X_MEM_SIZE >= F_MEM_SIZE &&
      ((X_MEM_SIZE - F_MEM_SIZE) % STRIDE) != 0) begin : g_chk_div
    $fatal(1, "STRIDE must divide X_MEM_SIZE-F_MEM_SIZE");
  end
  if (X_MEM_SIZE > (1 << X_MEM_ADDR_WIDTH) ||
      F_MEM_SIZE > (1 << F_MEM_ADDR_WIDTH)) begin : g_chk_aw
    $fatal(1, "memory size exceeds address width");
  end

  conv_out_state_e             state_q, state_d;
  logic [X_MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic                        abort_q, abort_d;
  logic                        start_pulse;
  logic                        last_beat;
  logic                        quit;
  logic [N_LANES-1:0]          last_mask;

  conv_start_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.conv_start),
    .pulse (start_pulse)
  );

  assign last_beat = (beat_q == BW'(N_BEATS - 1));
  assign quit      = abort_q | ~bus.conv_start;

  always_comb begin
    last_mask = '0;
    for (int i = 0; i < N_LANES; i++)
      if (i < LAST_LANES) last_mask[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        base_d = '0;
        beat_d = '0;
        if (start_pulse) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = bus.conv_start ? S_COMPUTE : S_IDLE;
      end
      S_COMPUTE: begin
        if (!bus.conv_start)   state_d = S_IDLE;
        else if (bus.mac_valid) state_d = S_OUT;
      end
      S_OUT: begin
        // an abort seen while stalled waits for the handshake
        abort_d = quit;
        if (bus.m_ready_y) begin
          abort_d = 1'b0;
          if (quit) begin
            state_d = S_IDLE;
          end else if (last_beat) begin
            state_d = S_DONE;
          end else begin
            base_d  = base_q + X_MEM_ADDR_WIDTH'(BEAT_STEP);
            beat_d  = beat_q + BW'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        base_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.load_xaddr_en  = (state_q == S_LOAD);
  assign bus.load_xaddr_val = base_q;
  assign bus.m_valid_y      = (state_q == S_OUT);
  assign bus.conv_done      = (state_q == S_DONE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.lane_mask      =
    (state_q inside {S_LOAD, S_COMPUTE, S_OUT}) ?
    (last_beat ? last_mask : '1) : '0;

`ifdef CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (start_pulse)
      stall_cnt <= '0;
    else if (bus.m_valid_y && !bus.m_ready_y && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ctrl_conv_output_par.sv
// Randomized bench for ctrl_conv_output_par: default and stride-2
// instances share stimulus; a beat-level model sets per-cycle expectations.
module tb_ctrl_conv_output_par;

  localparam int XS  = 8;
  localparam int FS  = 4;
  localparam int ST  = 1;
  localparam int NL  = 2;
  localparam int XS2 = 12;
  localparam int ST2 = 2;

  localparam int N_OUT      = (XS - FS) / ST + 1;
  localparam int N_BEATS    = (N_OUT + NL - 1) / NL;
  localparam int LAST_LANES = N_OUT - (N_BEATS - 1) * NL;
  localparam int STEP1      = NL * ST;
  localparam int STEP2      = NL * ST2;

  localparam int K_IDLE = 0;
  localparam int K_LOAD = 1;
  localparam int K_COMP = 2;
  localparam int K_OUT  = 3;
  localparam int K_DONE = 4;
  localparam int K_ZERO = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic conv_start = 1'b0;
  logic mac_valid = 1'b0;
  logic m_ready = 1'b0;

  always #5 clk = ~clk;

  ctrl_conv_output_par_if #(.X_MEM_ADDR_WIDTH(3), .N_LANES(NL)) bus1 ();
  ctrl_conv_output_par_if #(.X_MEM_ADDR_WIDTH(4), .N_LANES(NL)) bus2 ();

  assign bus1.conv_start = conv_start;
  assign bus1.mac_valid  = mac_valid;
  assign bus1.m_ready_y  = m_ready;
  assign bus2.conv_start = conv_start;
  assign bus2.mac_valid  = mac_valid;
  assign bus2.m_ready_y  = m_ready;

`ifdef CTRL_STALL_CNT_EN
  logic [15:0] stall1, stall2;
`endif

  ctrl_conv_output_par #(
    .F_MEM_SIZE(FS), .X_MEM_SIZE(XS), .STRIDE(ST), .N_LANES(NL),
    .X_MEM_ADDR_WIDTH(3), .F_MEM_ADDR_WIDTH(2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
`ifdef CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall1)
`endif
  );

  ctrl_conv_output_par #(
    .F_MEM_SIZE(FS), .X_MEM_SIZE(XS2), .STRIDE(ST2), .N_LANES(NL),
    .X_MEM_ADDR_WIDTH(4), .F_MEM_ADDR_WIDTH(2)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
`ifdef CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int e_kind = K_ZERO;
  int e_beat = 0;
  bit chk_on = 1'b0;
  int hs = 0;
  int dones = 0;
  int qb1[$];
  int qb2[$];
  int qm[$];
  int exp_stall = 0;
  bit prev_start = 1'b0;
  bit e_busy, e_en, e_valid, e_done;
  logic [NL-1:0] e_mask;

  function automatic logic [NL-1:0] mask_of(input int b);
    logic [NL-1:0] m;
    int n;
    m = '0;
    n = (b < N_BEATS - 1) ? NL : LAST_LANES;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        e_busy  = (e_kind == K_LOAD || e_kind == K_COMP ||
                   e_kind == K_OUT || e_kind == K_DONE);
        e_en    = (e_kind == K_LOAD);
        e_valid = (e_kind == K_OUT);
        e_done  = (e_kind == K_DONE);
        e_mask  = mask_of(e_beat);
        cmp("busy", bus1.busy, e_busy);
        cmp("load_en", bus1.load_xaddr_en, e_en);
        cmp("m_valid", bus1.m_valid_y, e_valid);
        cmp("done", bus1.conv_done, e_done);
        cmp("busy2", bus2.busy, e_busy);
        cmp("load_en2", bus2.load_xaddr_en, e_en);
        cmp("m_valid2", bus2.m_valid_y, e_valid);
        cmp("done2", bus2.conv_done, e_done);
        if (e_kind == K_LOAD || e_kind == K_COMP || e_kind == K_OUT) begin
          cmp("base", bus1.load_xaddr_val, e_beat * STEP1);
          cmp("mask", bus1.lane_mask, e_mask);
          cmp("base2", bus2.load_xaddr_val, e_beat * STEP2);
          cmp("mask2", bus2.lane_mask, e_mask);
        end
        if (e_kind == K_ZERO) begin
          cmp("zero_base", bus1.load_xaddr_val, 0);
          cmp("zero_mask", bus1.lane_mask, 0);
          cmp("zero_base2", bus2.load_xaddr_val, 0);
          cmp("zero_mask2", bus2.lane_mask, 0);
        end
`ifdef CTRL_STALL_CNT_EN
        cmp("stall_cnt", stall1, exp_stall);
        cmp("stall_cnt2", stall2, exp_stall);
`endif
        if (bus1.load_xaddr_en) begin
          qb1.push_back(int'(bus1.load_xaddr_val));
          qb2.push_back(int'(bus2.load_xaddr_val));
          qm.push_back(int'(bus1.lane_mask));
        end
        if (bus1.m_valid_y && m_ready) hs++;
        if (bus1.conv_done) dones++;
      end
    end
  end

  task automatic step();
    if (reset) exp_stall = 0;
    else if (conv_start && !prev_start) exp_stall = 0;
    else if (e_kind == K_OUT && !m_ready && exp_stall < 65535) exp_stall++;
    prev_start = reset ? 1'b0 : conv_start;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 full run, 1 abort in COMPUTE, 2 abort in OUT, 3 reset in OUT
  task automatic run(input int mode, input int ab, input int mac_d,
                     input int max_st, input int st_beat, input int st_len);
    int d;
    int s;
    conv_start = 1'b0;
    step();
    e_kind = K_IDLE;
    conv_start = 1'b1;
    step();
    for (int b = 0; b < N_BEATS; b++) begin
      e_kind = K_LOAD;
      e_beat = b;
      mac_valid = 1'($urandom % 2);
      m_ready = 1'($urandom % 2);
      step();
      e_kind = K_COMP;
      mac_valid = 1'b0;
      if (mode == 1 && b == ab) begin
        conv_start = 1'b0;
        step();
        e_kind = K_IDLE;
        return;
      end
      d = (mac_d < 0) ? $urandom_range(0, 3) : mac_d;
      repeat (d) step();
      mac_valid = 1'b1;
      step();
      e_kind = K_OUT;
      mac_valid = 1'b0;
      m_ready = 1'b0;
      if (mode == 3 && b == ab) begin
        reset = 1'b1;
        step();
        e_kind = K_ZERO;
        reset = 1'b0;
        conv_start = 1'b0;
        mac_valid = 1'b1;
        step();
        mac_valid = 1'b0;
        return;
      end
      if (mode == 2 && b == ab) conv_start = 1'b0;
      s = (b == st_beat) ? st_len : $urandom_range(0, max_st);
      repeat (s) begin
        mac_valid = 1'($urandom % 2);
        step();
      end
      mac_valid = 1'b0;
      m_ready = 1'b1;
      step();
      m_ready = 1'($urandom % 2);
      if (mode == 2 && b == ab) begin
        e_kind = K_IDLE;
        return;
      end
      if (b == N_BEATS - 1) e_kind = K_DONE;
    end
    step();
    e_kind = K_IDLE;
  endtask

  int lit_b1[3] = '{0, 2, 4};
  int lit_b2[3] = '{0, 4, 8};
  int lit_m[3]  = '{3, 3, 1};
  int d0;

  initial begin
    reset = 1'b1;
    e_kind = K_ZERO;
    step();
    chk_on = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    qb1.delete(); qb2.delete(); qm.delete();
    hs = 0; dones = 0;
    run(0, 0, 1, 0, -1, 0);
    cmp("run1_nstrobe", qb1.size(), 3);
    if (qb1.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        cmp("run1_base", qb1[i], lit_b1[i]);
        cmp("run1_base_s2", qb2[i], lit_b2[i]);
        cmp("run1_mask", qm[i], lit_m[i]);
      end
    end
    cmp("run1_handshakes", hs, 3);
    cmp("run1_dones", dones, 1);

    repeat (5) begin
      mac_valid = 1'($urandom % 2);
      step();
    end
    mac_valid = 1'b0;
    cmp("held_no_restart", qb1.size(), 3);

    qb1.delete(); qb2.delete(); qm.delete();
    run(0, 0, -1, 0, -1, 0);
    cmp("rerun_nstrobe", qb1.size(), 3);
    if (qb1.size() > 0) cmp("rerun_base0", qb1[0], 0);

    run(0, 0, -1, 0, 1, 5);
`ifdef CTRL_STALL_CNT_EN
    cmp("stall5", stall1, 5);
`endif

    d0 = dones;
    run(1, 2, -1, 2, -1, 0);
    cmp("abort_comp_nodone", dones, d0);
    run(2, 1, -1, 2, 1, 2);
    cmp("abort_out_nodone", dones, d0);
    run(3, 1, -1, 2, -1, 0);
    cmp("reset_out_nodone", dones, d0);

    repeat (40)
      run($urandom_range(0, 3), $urandom_range(0, N_BEATS - 1),
          -1, 3, -1, 0);

    conv_start = 1'b0;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
